// File: rtl/reg_ram_arbiter.sv
// Round-robin arbiter sharing the 4-byte register RAM between a CPU port (0) and a debug port (1).
// Each grant performs exactly one RAM access: IDLE -> GRANT (RAM enabled) -> ACK (requester pulse).
module reg_ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic              p0_req_in,
    input  logic              p0_we_in,
    input  logic [ADDR_W-1:0] p0_addr_in,
    input  logic [DATA_W-1:0] p0_data_in,
    output logic              p0_ack_out,
    output logic [DATA_W-1:0] p0_data_out,

    input  logic              p1_req_in,
    input  logic              p1_we_in,
    input  logic [ADDR_W-1:0] p1_addr_in,
    input  logic [DATA_W-1:0] p1_data_in,
    output logic              p1_ack_out,
    output logic [DATA_W-1:0] p1_data_out,

    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_we_out,
    output logic              ram_en_out,
    input  logic [DATA_W-1:0] ram_data_in,

    output logic              busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              take_grant;
    logic              pick_port;

    logic              gnt_port;
    logic              last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] p0_rdata;
    logic [DATA_W-1:0] p1_rdata;

    logic              in_grant;
    logic              in_ack;

    // Requests are only looked at in IDLE; on contention the port that did not win last time goes next.
    always_comb begin
        next_state = state;
        take_grant = 1'b0;
        pick_port  = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req_in || p1_req_in) begin
                    take_grant = 1'b1;
                    next_state = GRANT;
                    if (p0_req_in && p1_req_in) begin
                        pick_port = ~last_grant;
                    end else begin
                        pick_port = p1_req_in;
                    end
                end
            end
            GRANT:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // last_grant resets to 1 so port 0 wins the first contention after reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gnt_port   <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (take_grant) begin
            gnt_port   <= pick_port;
            last_grant <= pick_port;
            lat_we     <= pick_port ? p1_we_in   : p0_we_in;
            lat_addr   <= pick_port ? p1_addr_in : p0_addr_in;
            lat_wdata  <= pick_port ? p1_data_in : p0_data_in;
        end
    end

    // Read data is taken on the edge that closes GRANT, while the RAM is still presenting it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (in_grant && !lat_we) begin
            if (gnt_port) begin
                p1_rdata <= ram_data_in;
            end else begin
                p0_rdata <= ram_data_in;
            end
        end
    end

    assign in_grant = (state == GRANT);
    assign in_ack   = (state == ACK);

    // All RAM controls are decoded from registered state, so an async reset silences them at once.
    assign ram_en_out   = in_grant;
    assign ram_we_out   = in_grant && lat_we;
    assign ram_addr_out = in_grant ? lat_addr : '0;
    assign ram_data_out = (in_grant && lat_we) ? lat_wdata : '0;

    assign p0_ack_out   = in_ack && !gnt_port;
    assign p1_ack_out   = in_ack &&  gnt_port;
    assign p0_data_out  = p0_rdata;
    assign p1_data_out  = p1_rdata;
    assign busy_out     = (state != IDLE);

endmodule

// File: tb/tb_reg_ram_arbiter.sv
// Self-checking bench for reg_ram_arbiter with a behavioural RAM stand-in and a transaction-level model.
module tb_reg_ram_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] addr  [2];
    logic [7:0] wdata [2];

    logic       p0_ack_out, p1_ack_out;
    logic [7:0] p0_data_out, p1_data_out;
    logic [1:0] ram_addr_out;
    logic [7:0] ram_data_out;
    logic       ram_we_out, ram_en_out;
    logic [7:0] ram_data_in;
    logic       busy_out;

    logic [7:0] ram_cells [4];

    logic [7:0] mdl_mem [4];
    logic [7:0] pd [2];
    int         last;
    int         cyc;
    int         gnt_cyc;
    int         tests;
    int         errors;

    always #5 clk_in = ~clk_in;

    reg_ram_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .p0_req_in   (req[0]),
        .p0_we_in    (we[0]),
        .p0_addr_in  (addr[0]),
        .p0_data_in  (wdata[0]),
        .p0_ack_out  (p0_ack_out),
        .p0_data_out (p0_data_out),
        .p1_req_in   (req[1]),
        .p1_we_in    (we[1]),
        .p1_addr_in  (addr[1]),
        .p1_data_in  (wdata[1]),
        .p1_ack_out  (p1_ack_out),
        .p1_data_out (p1_data_out),
        .ram_addr_out(ram_addr_out),
        .ram_data_out(ram_data_out),
        .ram_we_out  (ram_we_out),
        .ram_en_out  (ram_en_out),
        .ram_data_in (ram_data_in),
        .busy_out    (busy_out)
    );

    // RAM stand-in: asynchronous read, synchronous write, cleared by the shared reset.
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 4; i++) ram_cells[i] <= 8'h00;
        end else if (ram_en_out && ram_we_out) begin
            ram_cells[ram_addr_out] <= ram_data_out;
        end
    end
    assign ram_data_in = (ram_en_out && !ram_we_out) ? ram_cells[ram_addr_out] : 8'h00;

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl_mem[i] = 8'h00;
        pd[0] = 8'h00;
        pd[1] = 8'h00;
        last  = 1;
    endtask

    task automatic new_req(input int p);
        req[p]   = 1'b1;
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = 2'($urandom_range(0, 3));
        wdata[p] = 8'($urandom);
    endtask

    task automatic set_req(input int p, input logic w, input logic [1:0] a, input logic [7:0] d);
        req[p]   = 1'b1;
        we[p]    = w;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    // Called in IDLE with inputs set; returns in the ACK cycle of the predicted winner.
    task automatic run_round(output int w);
        logic [14:0] exp_g;
        logic [14:0] got_g;
        logic [13:0] exp_a;
        logic [13:0] got_a;
        if (req == 2'b11) w = (last == 1) ? 0 : 1;
        else              w = req[0] ? 0 : 1;
        step();
        gnt_cyc = cyc;
        exp_g = {1'b1, we[w], addr[w], (we[w] ? wdata[w] : 8'h00), 2'b00, 1'b1};
        got_g = {ram_en_out, ram_we_out, ram_addr_out, ram_data_out, p1_ack_out, p0_ack_out, busy_out};
        tests++;
        if (got_g !== exp_g) begin
            errors++;
            $display("[TB] FAIL grant_cycle port%0d: got %h expected %h", w, got_g, exp_g);
        end
        if (we[w]) mdl_mem[addr[w]] = wdata[w];
        else       pd[w] = mdl_mem[addr[w]];
        last = w;
        step();
        exp_a = {1'b0, 1'b0, 2'b00, 8'h00, (w == 1) ? 2'b10 : 2'b01};
        got_a = {ram_en_out, ram_we_out, ram_addr_out, ram_data_out, p1_ack_out, p0_ack_out};
        tests++;
        if (got_a !== exp_a || busy_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_cycle port%0d: got %h busy %b expected %h busy 1", w, got_a, busy_out, exp_a);
        end
        tests++;
        if ({p0_data_out, p1_data_out} !== {pd[0], pd[1]}) begin
            errors++;
            $display("[TB] FAIL data_regs: got %h/%h expected %h/%h", p0_data_out, p1_data_out, pd[0], pd[1]);
        end
    endtask

    task automatic finish_round();
        step();
        tests++;
        if ({busy_out, ram_en_out, ram_we_out, p0_ack_out, p1_ack_out} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL idle_cycle: got busy/en/we/ack0/ack1 %b expected 00000",
                     {busy_out, ram_en_out, ram_we_out, p0_ack_out, p1_ack_out});
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [30:0] got;
        got = {p0_ack_out, p1_ack_out, p0_data_out, p1_data_out, ram_addr_out,
               ram_data_out, ram_we_out, ram_en_out, busy_out};
        tests++;
        if (got !== 31'd0) begin
            errors++;
            $display("[TB] FAIL %s: outputs got %h expected 0", name, got);
        end
    endtask

    task automatic test_reset();
        check_all_zero("reset_outputs");
        rst_in = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("idle_no_request");
        end
    endtask

    task automatic test_fairness();
        int w;
        int prev;
        set_req(0, 1'b0, 2'd0, 8'h00);
        set_req(1, 1'b1, 2'd1, 8'h3C);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_round(w);
            tests++;
            if (w != (i % 2)) begin
                errors++;
                $display("[TB] FAIL fair_order round %0d: got port%0d expected port%0d", i, w, i % 2);
            end
            if (i > 0) begin
                tests++;
                if (gnt_cyc - prev != 3) begin
                    errors++;
                    $display("[TB] FAIL grant_spacing: got %0d expected 3", gnt_cyc - prev);
                end
            end
            prev = gnt_cyc;
            if (i == 3) req = 2'b00;
            finish_round();
        end
    endtask

    task automatic test_write_p0();
        int w;
        int c0;
        set_req(0, 1'b1, 2'd2, 8'hA5);
        c0 = cyc;
        run_round(w);
        tests++;
        if (cyc - c0 != 2 || p0_ack_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_latency: got %0d cycles ack %b expected 2 cycles ack 1", cyc - c0, p0_ack_out);
        end
        req[0] = 1'b0;
        finish_round();
    endtask

    task automatic test_read_p1();
        int w;
        set_req(1, 1'b0, 2'd2, 8'h00);
        run_round(w);
        tests++;
        if (p1_data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL p1_read_a5: got %h expected a5", p1_data_out);
        end
        req[1] = 1'b0;
        finish_round();
    endtask

    task automatic test_fill_readback();
        int w;
        logic [7:0] expv;
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 2'(i), 8'(8'h11 * (i + 1)));
            run_round(w);
            req[0] = 1'b0;
            finish_round();
        end
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1'b0, 2'(i), 8'h00);
            run_round(w);
            expv = 8'(8'h11 * (i + 1));
            tests++;
            if (p1_data_out !== expv) begin
                errors++;
                $display("[TB] FAIL readback addr%0d: got %h expected %h", i, p1_data_out, expv);
            end
            req[1] = 1'b0;
            finish_round();
        end
    endtask

    task automatic test_reset_mid_grant();
        int w;
        set_req(0, 1'b1, 2'd3, 8'hFF);
        step();
        #2;
        rst_in = 1'b0;
        #1;
        check_all_zero("async_reset_in_grant");
        req = 2'b00;
        step();
        check_all_zero("reset_held_no_ack");
        step();
        check_all_zero("reset_held_idle");
        rst_in = 1'b1;
        model_reset();
        step();
        set_req(0, 1'b1, 2'd3, 8'h00);
        run_round(w);
        tests++;
        if (p0_data_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL aborted_write: got %h expected 00", p0_data_out);
        end
        req[0] = 1'b0;
        finish_round();
    endtask

    task automatic test_ack_change();
        int w;
        set_req(1, 1'b1, 2'd1, 8'h5A);
        run_round(w);
        addr[1]  = 2'd2;
        wdata[1] = 8'h77;
        finish_round();
        run_round(w);
        req[1] = 1'b0;
        set_req(0, 1'b0, 2'd1, 8'h00);
        finish_round();
        run_round(w);
        addr[0] = 2'd2;
        finish_round();
        run_round(w);
        req[0] = 1'b0;
        finish_round();
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 150; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] && $urandom_range(0, 1) == 1) new_req(p);
            end
            if (req == 2'b00) new_req(0);
            run_round(w);
            if ($urandom_range(0, 1) == 1) new_req(w);
            else                          req[w] = 1'b0;
            finish_round();
        end
        req = 2'b00;
        finish_round();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests    = 0;
        errors   = 0;
        cyc      = 0;
        gnt_cyc  = 0;
        rst_in   = 1'b0;
        req      = 2'b00;
        we       = 2'b00;
        addr[0]  = 2'd0;
        addr[1]  = 2'd0;
        wdata[0] = 8'h00;
        wdata[1] = 8'h00;
        model_reset();
        step();
        step();
        test_reset();
        test_fairness();
        test_write_p0();
        test_read_p1();
        test_fill_readback();
        test_reset_mid_grant();
        test_ack_change();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
